// File: rtl/spi_pkg.sv
// Shared SPI target definitions: mode encodings, FSM states, default frame width.
package spi_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        ABORT
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes sclk/cs/mosi onto prescale_clk and flags sclk leading/trailing edges against cpol.
// Latency: every output lags its pin by SYNC_STAGES+1 cycles, so cs, mosi and edges stay aligned.
// Backpressure: none; free-running sampler.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic prescale_clk,
    input  logic rst,
    input  logic cpol,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic sclk_lead,
    output logic sclk_trail,
    output logic cs_sync,
    output logic mosi_sync
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sclk_prev;

    always_ff @(posedge prescale_clk) begin
        if (rst) begin
            sclk_ff    <= {SYNC_STAGES{cpol}};
            cs_ff      <= '1;
            mosi_ff    <= '0;
            sclk_prev  <= cpol;
            sclk_lead  <= 1'b0;
            sclk_trail <= 1'b0;
            cs_sync    <= 1'b1;
            mosi_sync  <= 1'b0;
        end else begin
            sclk_ff    <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            cs_ff      <= {cs_ff[SYNC_STAGES-2:0], cs};
            mosi_ff    <= {mosi_ff[SYNC_STAGES-2:0], mosi};
            sclk_prev  <= sclk_ff[SYNC_STAGES-1];
            sclk_lead  <= (sclk_prev == cpol) && (sclk_ff[SYNC_STAGES-1] != cpol);
            sclk_trail <= (sclk_prev != cpol) && (sclk_ff[SYNC_STAGES-1] == cpol);
            // cs and mosi get one extra flop to line up with the registered edge strobes
            cs_sync    <= cs_ff[SYNC_STAGES-1];
            mosi_sync  <= mosi_ff[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI target engine, all cpol/cpha modes, DATA_W-bit frames; SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting.
// Latency: pin edge seen after SYNC_STAGES+1 cycles; rx_valid rises 2 cycles after the last sample is detected.
// Backpressure: none toward the master; unread rx is overwritten (rx_overrun), empty tx buffer retransmits.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              prescale_clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    logic              sclk_lead;
    logic              sclk_trail;
    logic              cs_sync;
    logic              mosi_sync;
    logic              sample_edge;
    logic              shift_edge;
    spi_state_t        state;
    logic [DATA_W-1:0] tx_buf;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] rx_next;
    logic [CNT_W-1:0]  bit_cnt;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .prescale_clk (prescale_clk),
        .rst          (rst),
        .cpol         (cpol),
        .sclk         (sclk),
        .cs           (cs),
        .mosi         (mosi),
        .sclk_lead    (sclk_lead),
        .sclk_trail   (sclk_trail),
        .cs_sync      (cs_sync),
        .mosi_sync    (mosi_sync)
    );

    assign sample_edge = cpha ? sclk_trail : sclk_lead;
    assign shift_edge  = cpha ? sclk_lead  : sclk_trail;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return v[0];
    endfunction
    function automatic logic [DATA_W-1:0] pop_bit(input logic [DATA_W-1:0] v);
        return {1'b0, v[DATA_W-1:1]};
    endfunction
    assign rx_next = {mosi_sync, rx_sh[DATA_W-1:1]};
`else
    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return v[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] pop_bit(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], 1'b0};
    endfunction
    assign rx_next = {rx_sh[DATA_W-2:0], mosi_sync};
`endif

    always_ff @(posedge prescale_clk) begin
        if (rst) begin
            state      <= IDLE;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            tx_ready   <= 1'b1;
            tx_buf     <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            frame_err <= 1'b0;
            if (rx_ack) rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    miso    <= 1'b0;
                    if (!cs_sync) state <= LOAD;
                end
                LOAD: begin
                    tx_ready <= 1'b1;
                    miso_oe  <= 1'b1;
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    if (!cpha) begin
                        miso  <= head_bit(tx_buf);
                        tx_sh <= pop_bit(tx_buf);
                    end else begin
                        tx_sh <= tx_buf;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    // Deselect before any sample is a clean end after a back-to-back reload, not a torn frame
                    if (cs_sync) begin
                        if (bit_cnt == '0) begin
                            miso_oe <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state <= ABORT;
                        end
                    end else begin
                        if (shift_edge && (cpha || bit_cnt != '0)) begin
                            miso  <= head_bit(tx_sh);
                            tx_sh <= pop_bit(tx_sh);
                        end
                        if (sample_edge) begin
                            rx_sh   <= rx_next;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_W'(DATA_W - 1)) state <= DONE;
                        end
                    end
                end
                DONE: begin
                    rx_data  <= rx_sh;
                    rx_valid <= 1'b1;
                    if (rx_valid && !rx_ack) rx_overrun <= 1'b1;
                    if (cs_sync) begin
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
                ABORT: begin
                    frame_err <= 1'b1;
                    miso_oe   <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (tx_load && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: bus-functional SPI master with hand-computed expected frames.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    localparam int T_HALF = 80;

    logic       prescale_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       cpol    = 1'b0;
    logic       cpha    = 1'b0;
    logic       sclk    = 1'b0;
    logic       cs      = 1'b1;
    logic       mosi    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       rx_ack  = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad = 0;
    int ferr_cycles = 0;
    logic [7:0] rxq[$];

    spi_slave_ctrl dut (
        .prescale_clk (prescale_clk),
        .rst          (rst),
        .cpol         (cpol),
        .cpha         (cpha),
        .sclk         (sclk),
        .cs           (cs),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_overrun   (rx_overrun),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 prescale_clk = ~prescale_clk;

    always @(posedge prescale_clk) begin
        #1;
        if (frame_err) ferr_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"},     miso,       0);
        chk({tag, "_miso_oe"},  miso_oe,    0);
        chk({tag, "_tx_ready"}, tx_ready,   1);
        chk({tag, "_rx_data"},  rx_data,    0);
        chk({tag, "_rx_valid"}, rx_valid,   0);
        chk({tag, "_overrun"},  rx_overrun, 0);
        chk({tag, "_ferr"},     frame_err,  0);
        chk({tag, "_busy"},     busy,       0);
    endtask

    task automatic set_mode(input logic p, input logic h);
        @(negedge prescale_clk);
        cs = 1'b1; cpol = p; cpha = h; sclk = p;
        repeat (10) @(negedge prescale_clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge prescale_clk);
        tx_data = d; tx_load = 1'b1;
        @(negedge prescale_clk);
        tx_load = 1'b0;
    endtask

    task automatic ack_rx();
        @(negedge prescale_clk); rx_ack = 1'b1;
        @(negedge prescale_clk); rx_ack = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge prescale_clk);
        cs = 1'b0;
        #(T_HALF);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (10) @(negedge prescale_clk);
    endtask

    // SPI master: MSB first, samples miso on the edge where the slave samples mosi
    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                mosi = tx[n-1-i];
                #(T_HALF); sclk = ~cpol; rx = {rx[30:0], miso};
                #(T_HALF); sclk = cpol;
            end else begin
                sclk = ~cpol; mosi = tx[n-1-i];
                #(T_HALF); sclk = cpol; rx = {rx[30:0], miso};
                #(T_HALF);
            end
        end
    endtask

    task automatic frame(input logic [7:0] slave_tx, input logic [7:0] master_tx, output logic [7:0] got);
        logic [31:0] r;
        load_tx(slave_tx);
        cs_low();
        spi_bits({24'h0, master_tx}, 8, r);
        got = r[7:0];
        #(T_HALF);
        cs_high();
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  got;
        int f0;

        repeat (3) @(negedge prescale_clk);
        rst = 1'b0;
        repeat (2) @(negedge prescale_clk);
        chk_reset_vals("rst0");

        // Mode 0 basic frame
        load_tx(8'hA5);
        chk("m0_tx_ready_loaded", tx_ready, 0);
        cs_low();
        chk("m0_tx_ready_after_load", tx_ready, 1);
        chk("m0_busy", busy, 1);
        chk("m0_miso_oe", miso_oe, 1);
        spi_bits(32'h3C, 8, r);
        #(T_HALF);
        cs_high();
        chk("m0_miso_bits", r[7:0], 8'hA5);
        chk("m0_rx_data", rx_data, 8'h3C);
        chk("m0_rx_valid", rx_valid, 1);
        chk("m0_ferr", ferr_cycles, 0);
        chk("m0_busy_idle", busy, 0);
        chk("m0_oe_idle", miso_oe, 0);
        ack_rx();
        chk("m0_ack_clears", rx_valid, 0);

        // All four modes
        for (int m = 0; m < 4; m++) begin
            set_mode(logic'(m >> 1), logic'(m & 1));
            load_tx(8'h7E);
            cs_low();
            spi_bits(32'h81, 8, r);
            chk($sformatf("mode%0d_valid_in_half", m), rx_valid, 1);
            #(T_HALF);
            cs_high();
            chk($sformatf("mode%0d_miso", m), r[7:0], 8'h7E);
            chk($sformatf("mode%0d_rx", m), rx_data, 8'h81);
            ack_rx();
        end

        // Back-to-back frames under one cs
        set_mode(1'b0, 1'b0);
        load_tx(8'h11);
        cs_low();
        chk("b2b_ready_mid", tx_ready, 1);
        load_tx(8'h22);
        fork
            spi_bits(32'hC35A, 16, r);
            begin
                for (int k = 0; k < 320; k++) begin
                    @(negedge prescale_clk);
                    if (rx_valid && !rx_ack) begin
                        rxq.push_back(rx_data);
                        rx_ack = 1'b1;
                    end else begin
                        rx_ack = 1'b0;
                    end
                end
                rx_ack = 1'b0;
            end
        join
        cs_high();
        chk("b2b_count", rxq.size(), 2);
        chk("b2b_rx0", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'hC3);
        chk("b2b_rx1", (rxq.size() > 1) ? rxq[1] : 8'hxx, 8'h5A);
        chk("b2b_miso", r[15:0], 16'h1122);
        chk("b2b_ferr", ferr_cycles, 0);

        // Overrun and ack-during-DONE
        frame(8'h00, 8'h12, got);
        chk("ovr_a_valid", rx_valid, 1);
        chk("ovr_a_flag", rx_overrun, 0);
        load_tx(8'h00);
        cs_low();
        fork
            spi_bits(32'h34, 8, r);
            begin
                for (int k = 0; k < 300; k++) begin
                    @(negedge prescale_clk);
                    if (dut.state == DONE) begin
                        rx_ack = 1'b1;
                        @(negedge prescale_clk);
                        rx_ack = 1'b0;
                        break;
                    end
                end
            end
        join
        #(T_HALF);
        cs_high();
        chk("ack_done_valid", rx_valid, 1);
        chk("ack_done_no_ovr", rx_overrun, 0);
        chk("ack_done_data", rx_data, 8'h34);
        frame(8'h00, 8'h56, got);
        chk("ovr_c_flag", rx_overrun, 1);
        chk("ovr_c_data", rx_data, 8'h56);
        ack_rx();
        chk("ovr_ack_valid", rx_valid, 0);
        chk("ovr_sticky", rx_overrun, 1);

        // cs raised after 5 bits
        f0 = ferr_cycles;
        cs_low();
        spi_bits(32'hFF, 5, r);
        cs_high();
        chk("abort_pulse", ferr_cycles - f0, 1);
        chk("abort_valid", rx_valid, 0);
        chk("abort_data", rx_data, 8'h56);
        chk("abort_oe", miso_oe, 0);
        chk("abort_busy", busy, 0);

        // Reset mid-frame, then a clean frame
        load_tx(8'hF0);
        cs_low();
        spi_bits(32'hAA, 3, r);
        @(negedge prescale_clk);
        rst = 1'b1;
        @(negedge prescale_clk);
        chk_reset_vals("rst_mid");
        cs = 1'b1; sclk = cpol;
        @(negedge prescale_clk);
        rst = 1'b0;
        repeat (10) @(negedge prescale_clk);
        frame(8'h96, 8'h69, got);
        chk("post_rst_miso", got, 8'h96);
        chk("post_rst_rx", rx_data, 8'h69);
        chk("post_rst_valid", rx_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
